sram_access_ctrl: RTL and testbench

Sequencing controller and two-port arbiter for the off-chip-style SRAM. It sits between the pipeline MEM stage (port 0) and a secondary requester such as a display or DMA reader (port 1), and grants one request at a time. For each granted request it drives the SRAM address, write-enable and data bus, waits a fixed number of wait-states and returns either read data or write completion. It owns the SRAM bidirectional bus; no other block may drive it.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/sram_rr_arb2.sv | 42 ++++
 rtl/sram_access_ctrl.sv | 121 ++++++++++++
 tb/tb_sram_access_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and widths for the SRAM access controller.
// Imported by sram_rr_arb2 and sram_access_ctrl.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 17;
  localparam int SRAM_DQ_W   = 64;
  localparam int REQ_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Byte address to SRAM word index.
  function automatic logic [SRAM_ADDR_W-1:0] word_idx(
    input logic [31:0] a
  );
    return a[18:2];
  endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-input arbiter; SRAM_CTRL_RR_EN selects round-robin ties,
// otherwise port 0 wins ties and no last-grant state exists.
import sram_ctrl_pkg::*;

module sram_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic gnt
);

`ifdef SRAM_CTRL_RR_EN
  logic last;

  // Remember which port won the most recent grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last <= 1'b1;
    else if (take && (req0 || req1)) last <= gnt;
  end

  // On a tie the port not granted last wins.
  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      req0 && req1:  gnt = ~last;
      !req0 && req1: gnt = 1'b1;
      default:       gnt = 1'b0;
    endcase
  end
`else
  logic unused_arb;
  assign unused_arb = clk ^ rst ^ take;

  // Fixed priority: port 1 only when port 0 is silent.
  always_comb begin
    gnt = !req0 && req1;
  end
`endif

endmodule

// File: rtl/sram_access_ctrl.sv
// Two-port SRAM sequencer: grant, fixed wait-state access, done pulse.
// Define SRAM_CTRL_RR_EN for round-robin tie breaking.
import sram_ctrl_pkg::*;

module sram_access_ctrl #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic                   req0_we,
  input  logic [31:0]            req0_addr,
  input  logic [REQ_DATA_W-1:0]  req0_wdata,
  output logic                   req0_done,
  output logic [SRAM_DQ_W-1:0]   req0_rdata,
  input  logic                   req1_valid,
  input  logic                   req1_we,
  input  logic [31:0]            req1_addr,
  input  logic [REQ_DATA_W-1:0]  req1_wdata,
  output logic                   req1_done,
  output logic [SRAM_DQ_W-1:0]   req1_rdata,
  output logic                   busy,
  output logic                   sram_we_n,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  inout  wire  [SRAM_DQ_W-1:0]   sram_dq
);

  localparam int CW = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  state_e                 state;
  logic [CW-1:0]          cnt;
  logic                   l_we;
  logic                   l_port;
  logic [SRAM_ADDR_W-1:0] l_addr;
  logic [REQ_DATA_W-1:0]  l_wdata;
  logic                   any;
  logic                   gnt;
  logic                   wr_drv;
  logic                   last_beat;

  logic unused_addr;
  assign unused_addr = ^{req0_addr[31:19], req0_addr[1:0],
                         req1_addr[31:19], req1_addr[1:0]};

  assign any       = req0_valid || req1_valid;
  assign wr_drv    = (state == ACCESS) && l_we;
  assign last_beat = (state == ACCESS) && (cnt == LAST);

  sram_rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0_valid),
    .req1 (req1_valid),
    .take (state == IDLE),
    .gnt  (gnt)
  );

  // FSM, wait counter and grant-time capture of requester fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      l_we    <= 1'b0;
      l_port  <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            l_port  <= gnt;
            l_we    <= gnt ? req1_we : req0_we;
            l_addr  <= word_idx(gnt ? req1_addr : req0_addr);
            l_wdata <= gnt ? req1_wdata : req0_wdata;
            cnt     <= '0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == LAST) state <= DONE;
          else cnt <= cnt + 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read capture at the final access edge into the granted port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else if (last_beat && !l_we) begin
      if (l_port) req1_rdata <= sram_dq;
      else req0_rdata <= sram_dq;
    end
  end

  // Done pulse and busy flag; busy spans grant through the done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      req0_done <= (state == DONE) && !l_port;
      req1_done <= (state == DONE) && l_port;
      if (state == IDLE) busy <= any;
      else busy <= 1'b1;
    end
  end

  assign sram_addr = (state == ACCESS) ? l_addr : '0;
  assign sram_we_n = !wr_drv;
  assign sram_dq   = wr_drv
                   ? {{(SRAM_DQ_W-REQ_DATA_W){1'b0}}, l_wdata}
                   : {SRAM_DQ_W{1'bz}};

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl with an SRAM device model.
// Honours SRAM_CTRL_RR_EN for tie-order prediction.
`timescale 1ns/1ps
module tb_sram_access_ctrl;

  localparam int WC = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_done, req1_done, busy, sram_we_n;
  logic [63:0] req0_rdata, req1_rdata;
  logic [16:0] sram_addr;
  tri1  [63:0] sram_dq;
  logic [63:0] rd_word;
  logic        tb_drv;

  assign tb_drv  = busy && sram_we_n;
  assign sram_dq = tb_drv ? rd_word : 64'bz;

  sram_access_ctrl #(.WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_done(req1_done), .req1_rdata(req1_rdata),
    .busy(busy), .sram_we_n(sram_we_n),
    .sram_addr(sram_addr), .sram_dq(sram_dq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // SRAM contents: device model and reference model.
  logic [31:0] dev  [int];
  logic [31:0] refm [int];

  function automatic logic [31:0] init_word(int i);
    return 32'h5A5A_0000 ^ (i * 32'h0100_0193);
  endfunction

  function automatic logic [31:0] dev_rd(int i);
    return dev.exists(i) ? dev[i] : init_word(i);
  endfunction

  function automatic logic [31:0] ref_rd(int i);
    return refm.exists(i) ? refm[i] : init_word(i);
  endfunction

  // SRAM device: absorb writes, present the addressed word pair.
  always @(negedge clk) begin
    if (!sram_we_n) dev[int'(sram_addr)] = sram_dq[31:0];
    rd_word = {dev_rd(int'(sram_addr) | 1),
               dev_rd(int'(sram_addr) & ~1)};
  end

  // Reference model state.
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic        m_last = 1'b1;
  logic [63:0] m_rd0 = '0;
  logic [63:0] m_rd1 = '0;

  function automatic int tie_winner();
`ifdef SRAM_CTRL_RR_EN
    return m_last ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  task automatic model_grant(int p, logic we, logic [31:0] a,
                             logic [31:0] d);
    int i;
    i = int'(a[18:2]);
    if (we) refm[i] = d;
    else if (p == 0) m_rd0 = {ref_rd(i | 1), ref_rd(i & ~1)};
    else m_rd1 = {ref_rd(i | 1), ref_rd(i & ~1)};
    if (p == 0) exp_q0.push_back(m_rd0);
    else exp_q1.push_back(m_rd1);
    m_last = (p != 0);
  endtask

  // Monitor: pop and compare on every done; police write strobes.
  int wl = 0;
  always @(negedge clk) begin
    if (req0_done) begin
      if (exp_q0.size() == 0) fail_now("unexpected_done0");
      else chk("rdata0", req0_rdata, exp_q0.pop_front());
    end
    if (req1_done) begin
      if (exp_q1.size() == 0) fail_now("unexpected_done1");
      else chk("rdata1", req1_rdata, exp_q1.pop_front());
    end
    if (rst) wl = 0;
    else if (!sram_we_n) begin
      wl++;
      chk("dq_upper_zero", {32'b0, sram_dq[63:32]}, 64'd0);
    end else if (wl != 0) begin
      chk("we_n_low_len", wl, WC);
      wl = 0;
    end
  end

  task automatic set_req(int p, logic v, logic we, logic [31:0] a,
                         logic [31:0] d);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  // Single request; optionally perturbs the address after grant.
  task automatic single(int p, logic we, logic [31:0] a,
                        logic [31:0] d, bit chg);
    int  n;
    bit  got;
    got = 0;
    set_req(p, 1'b1, we, a, d);
    model_grant(p, we, a, d);
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (chg && n == 2) begin
        if (p == 0) req0_addr = a ^ 32'h0000_0300;
        else req1_addr = a ^ 32'h0000_0300;
      end
      if (n == 3) begin
        chk("sram_addr", sram_addr, a[18:2]);
        chk("sram_we_n", sram_we_n, !we);
      end
      if ((p == 0 && req0_done) || (p == 1 && req1_done)) begin
        got = 1;
        break;
      end
    end
    if (p == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
    if (!got) fail_now("single_timeout");
    else chk("latency", n, WC + 2);
  endtask

  // Both ports request together; winner served first, loser next.
  task automatic tie(logic we0, logic [31:0] a0, logic [31:0] d0,
                     logic we1, logic [31:0] a1, logic [31:0] d1);
    int w, first;
    bit s0, s1;
    w = tie_winner();
    first = -1;
    s0 = 0;
    s1 = 0;
    set_req(0, 1'b1, we0, a0, d0);
    set_req(1, 1'b1, we1, a1, d1);
    if (w == 0) begin
      model_grant(0, we0, a0, d0);
      model_grant(1, we1, a1, d1);
    end else begin
      model_grant(1, we1, a1, d1);
      model_grant(0, we0, a0, d0);
    end
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (req0_done && !s0) begin
        s0 = 1;
        if (first < 0) first = 0;
        req0_valid = 1'b0;
        chk("tie_lat0", n, (w == 0) ? WC + 2 : 2 * (WC + 2));
      end
      if (req1_done && !s1) begin
        s1 = 1;
        if (first < 0) first = 1;
        req1_valid = 1'b0;
        chk("tie_lat1", n, (w == 1) ? WC + 2 : 2 * (WC + 2));
      end
      if (s0 && s1) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!(s0 && s1)) fail_now("tie_timeout");
    else chk("tie_winner", first, w);
  endtask

  // Both ports held for three grants back to back.
  task automatic hold_both3();
    int exp_order[3];
    int got_order[3];
    int k;
    k = 0;
    set_req(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h0000_0800, 32'h0);
    for (int r = 0; r < 3; r++) begin
      exp_order[r] = tie_winner();
      model_grant(exp_order[r], 1'b0,
                  exp_order[r] != 0 ? 32'h0000_0800 : 32'h0000_0400,
                  32'h0);
    end
    for (int n = 1; n <= 60 && k < 3; n++) begin
      @(negedge clk);
      if (req0_done) got_order[k++] = 0;
      else if (req1_done) got_order[k++] = 1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (k < 3) fail_now("rounds_timeout");
    else for (int r = 0; r < 3; r++)
      chk($sformatf("round%0d_grant", r), got_order[r], exp_order[r]);
  endtask

  // Reset in the third access cycle of a write.
  task automatic reset_mid();
    set_req(1, 1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    refm[int'(32'h0000_0300 >> 2)] = 32'hCAFE_F00D;
    m_last = 1'b1;
    m_rd0 = '0;
    m_rd1 = '0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_dq_released", sram_dq, {64{1'b1}});
    chk("rst_done1", req1_done, 1'b0);
    #1 rst = 1'b0;
    req1_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_rdata0", req0_rdata, 64'd0);
    chk("rst_rdata1", req1_rdata, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", {req1_done, req0_done}, 2'b00);
    chk("reset_rdata0", req0_rdata, 64'd0);
    chk("reset_rdata1", req1_rdata, 64'd0);
    chk("reset_we_n", sram_we_n, 1'b1);
    chk("reset_addr", sram_addr, 17'd0);
    chk("reset_dq", sram_dq, {64{1'b1}});
    #1 rst = 1'b0;
    @(negedge clk);

    dev[32'h40]  = 32'hAAAA_5555;
    dev[32'h41]  = 32'h1234_5678;
    refm[32'h40] = 32'hAAAA_5555;
    refm[32'h41] = 32'h1234_5678;
    single(0, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    chk("read_pair", req0_rdata, 64'h1234_5678_AAAA_5555);

    single(1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0);
    single(1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
    chk("wr_rd_low", {32'b0, req1_rdata[31:0]}, 64'hDEAD_BEEF);

    hold_both3();
    repeat (2) @(negedge clk);

    single(0, 1'b0, 32'h0000_0100, 32'h0, 1'b1);
    chk("addr_change_data", req0_rdata, 64'h1234_5678_AAAA_5555);

    reset_mid();
    single(1, 1'b0, 32'h0000_0300, 32'h0, 1'b0);

    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (sram_dq !== {64{1'b1}} || sram_we_n !== 1'b1) bad++;
    end
    chk("idle_bus_bad_cycles", bad, 0);

    for (int t = 0; t < 30; t++) begin
      int kind;
      logic [31:0] a0, a1;
      kind = $urandom_range(0, 2);
      a0 = ($urandom & 32'hFFF8_0003) | (32'($urandom_range(0, 31)) << 2);
      a1 = ($urandom & 32'hFFF8_0003) | (32'($urandom_range(0, 31)) << 2);
      if (kind == 2)
        tie(1'($urandom_range(0, 1)), a0, $urandom,
            1'($urandom_range(0, 1)), a1, $urandom);
      else
        single(kind, 1'($urandom_range(0, 1)), a0, $urandom, 1'b0);
    end

    repeat (10) @(negedge clk);
    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
